// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Synchronizes and debounces a bank of slow mechanical switch inputs. Each bit
// passes through a two-flop synchronizer, then an independent stability
// counter. An output bit takes a new level only after its synchronized input
// has disagreed with the current output for STABLE_CYCLES consecutive cycles.
// A bounce that returns to the current output level clears that bit's count.
//
// Parameters:
//   WIDTH         number of independent switch bits
//   STABLE_CYCLES consecutive mismatch cycles needed to flip an output (>= 1)
//   RESET_VAL     reset level of sw_out and of both synchronizer stages
//
// Ports:
//   clk         single clock
//   rst_n       asynchronous, active-low reset
//   sw_in       raw asynchronous pin levels
//   sw_out      debounced, registered levels
//   sw_rise     one-cycle pulse per bit when sw_out goes 0->1
//   sw_fall     one-cycle pulse per bit when sw_out goes 1->0
//   any_change  registered OR of all rise/fall pulses, coincident with them
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int               WIDTH         = 16,
  parameter int               STABLE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  // Count value at which the next mismatching edge completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] flip;

  // A bit flips on the edge where it still mismatches and its count has
  // already reached the last value; the counter therefore never passes
  // CNT_LAST and never wraps.
  always_comb begin
    mismatch = sync2 ^ sw_out;
    flip     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = mismatch[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Stage 1: two-flop synchronizer. Resetting to RESET_VAL keeps it equal to
  // sw_out so reset release cannot produce a spurious pulse on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Stage 2: per-bit stability counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage 3: debounced level and edge pulses, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_out     <= RESET_VAL;
      sw_rise    <= '0;
      sw_fall    <= '0;
      any_change <= 1'b0;
    end else begin
      sw_out     <= sw_out ^ flip;
      sw_rise    <= flip & sync2;
      sw_fall    <= flip & ~sync2;
      any_change <= |flip;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Bench for switch_debounce. Two instances share clock, reset and inputs:
// dut4 (STABLE_CYCLES=4) and dut1 (STABLE_CYCLES=1). The reference model keeps
// a history of sampled input words; an output bit flips when the last N
// synchronized samples all disagree with its current level.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_in = 16'hFFFF;

  logic [15:0] out4, rise4, fall4, out1, rise1, fall1;
  logic        chg4, chg1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(16), .STABLE_CYCLES(4), .RESET_VAL(16'h0000)) dut4 (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .sw_out(out4), .sw_rise(rise4), .sw_fall(fall4), .any_change(chg4)
  );

  switch_debounce #(.WIDTH(16), .STABLE_CYCLES(1), .RESET_VAL(16'h0000)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .sw_out(out1), .sw_rise(rise1), .sw_fall(fall1), .any_change(chg1)
  );

  // ---------------------------------------------------------------------------
  // Reference model. q holds sw_in as sampled on each edge; the synchronized
  // value seen on an edge is the sample from two edges earlier. Leading zeros
  // stand for the synchronizer's reset level.
  // ---------------------------------------------------------------------------
  logic [15:0] q[$];
  logic [15:0] m_out  [2];
  logic [15:0] m_rise [2];
  logic [15:0] m_fall [2];
  logic        m_chg  [2];
  logic [15:0] stable;
  int          n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(16'h0000);
      for (int k = 0; k < 2; k++) begin
        m_out[k]  = 16'h0000;
        m_rise[k] = 16'h0000;
        m_fall[k] = 16'h0000;
        m_chg[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        n      = (k == 0) ? 4 : 1;
        stable = 16'hFFFF;
        for (int j = 0; j < n; j++) stable &= q[q.size() - 2 - j] ^ m_out[k];
        m_rise[k] = stable & ~m_out[k];
        m_fall[k] = stable & m_out[k];
        m_out[k]  = m_out[k] ^ stable;
        m_chg[k]  = |stable;
      end
      q.push_back(sw_in);
      if (q.size() > 16) void'(q.pop_front());
    end
  end

  logic [129:0] act, expv;
  assign act  = {out4, rise4, fall4, chg4, out1, rise1, fall1, chg1};
  assign expv = {m_out[0], m_rise[0], m_fall[0], m_chg[0],
                 m_out[1], m_rise[1], m_fall[1], m_chg[1]};

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    sw_in = 16'hFFFF;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (out4 !== 16'h0 || rise4 !== 16'h0 || fall4 !== 16'h0 || chg4 !== 1'b0 ||
          out1 !== 16'h0 || chg1 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: out4=%h rise4=%h chg4=%b out1=%h, want all 0",
                 out4, rise4, chg4, out1);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL reset_release_model e=%0d: got %h want %h", e, act, expv);
      end
      vectors++;
      if (out4 !== (e >= 6 ? 16'hFFFF : 16'h0000) ||
          rise4 !== (e == 6 ? 16'hFFFF : 16'h0000) || chg4 !== (e == 6)) begin
        miscompares++;
        $display("FAIL reset_release_n4 e=%0d: out=%h rise=%h chg=%b", e, out4, rise4, chg4);
      end
      vectors++;
      if (out1 !== (e >= 3 ? 16'hFFFF : 16'h0000) ||
          rise1 !== (e == 3 ? 16'hFFFF : 16'h0000) || chg1 !== (e == 3)) begin
        miscompares++;
        $display("FAIL reset_release_n1 e=%0d: out=%h rise=%h chg=%b", e, out1, rise1, chg1);
      end
    end
  endtask

  task automatic test_clean_edge();
    sw_in = 16'h0000;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL clean_settle: got %h want %h", act, expv);
      end
    end
    sw_in[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv || out4[3] !== (e >= 6) ||
          rise4 !== (e == 6 ? 16'h0008 : 16'h0000) || fall4 !== 16'h0000) begin
        miscompares++;
        $display("FAIL clean_rise e=%0d: out=%h rise=%h fall=%h model=%h",
                 e, out4, rise4, fall4, m_out[0]);
      end
    end
    sw_in[3] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv || out4[3] !== (e < 6) ||
          fall4 !== (e == 6 ? 16'h0008 : 16'h0000) || rise4 !== 16'h0000) begin
        miscompares++;
        $display("FAIL clean_fall e=%0d: out=%h rise=%h fall=%h model=%h",
                 e, out4, rise4, fall4, m_out[0]);
      end
    end
  endtask

  task automatic test_bounce();
    int hold;
    int rise_cnt;
    int rise_edge;
    for (int t = 0; t < 4; t++) begin
      sw_in[0] = (t % 2 == 0);
      hold = $urandom_range(1, 2);
      repeat (hold) begin
        @(negedge clk);
        vectors++;
        if (act !== expv || rise4[0] !== 1'b0 || fall4[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL bounce_quiet: rise4=%h fall4=%h act=%h want %h", rise4, fall4, act, expv);
        end
      end
    end
    sw_in[0]  = 1'b1;
    rise_cnt  = 0;
    rise_edge = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv || fall4[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_model e=%0d: got %h want %h", e, act, expv);
      end
      if (rise4[0] === 1'b1) begin
        rise_cnt++;
        rise_edge = e;
      end
    end
    vectors++;
    if (rise_cnt != 1 || rise_edge != 6) begin
      miscompares++;
      $display("FAIL bounce_single_rise: count=%0d edge=%0d, want count=1 edge=6",
               rise_cnt, rise_edge);
    end
  endtask

  task automatic test_glitch();
    sw_in[9] = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      if (e == 3) sw_in[9] = 1'b0;
      vectors++;
      if (act !== expv || out4[9] !== 1'b0 || rise4[9] !== 1'b0 || fall4[9] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch e=%0d: out4=%h rise4=%h got %h want %h", e, out4, rise4, act, expv);
      end
    end
    vectors++;
    if (dut4.cnt[9] !== 3'd0) begin
      miscompares++;
      $display("FAIL glitch_cnt: cnt[9]=%0d, want 0", dut4.cnt[9]);
    end
  endtask

  task automatic test_simultaneous();
    sw_in[12] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL simul_settle: got %h want %h", act, expv);
      end
    end
    sw_in[1]  = 1'b1;
    sw_in[12] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 2) sw_in[5] = 1'b1;
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL simul_model e=%0d: got %h want %h", e, act, expv);
      end
      if (e == 6) begin
        vectors++;
        if (rise4 !== 16'h0002 || fall4 !== 16'h1000 || chg4 !== 1'b1 ||
            out4[5] !== 1'b0 || dut4.cnt[5] !== 3'd2) begin
          miscompares++;
          $display("FAIL simul_edge: rise=%h fall=%h chg=%b out5=%b cnt5=%0d",
                   rise4, fall4, chg4, out4[5], dut4.cnt[5]);
        end
      end
      if (e == 7) begin
        vectors++;
        if (chg4 !== 1'b0 || rise4 !== 16'h0000) begin
          miscompares++;
          $display("FAIL simul_one_cycle: chg=%b rise=%h, want 0", chg4, rise4);
        end
      end
      if (e == 8) begin
        vectors++;
        if (rise4 !== 16'h0020 || chg4 !== 1'b1) begin
          miscompares++;
          $display("FAIL simul_bit5: rise=%h chg=%b, want 0020 1", rise4, chg4);
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    sw_in[7] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL midcount_model: got %h want %h", act, expv);
      end
    end
    vectors++;
    if (dut4.cnt[7] !== 3'd2 || out4[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL midcount_cnt: cnt[7]=%0d out7=%b, want 2 0", dut4.cnt[7], out4[7]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out4 !== 16'h0 || rise4 !== 16'h0 || fall4 !== 16'h0 || chg4 !== 1'b0 ||
        out1 !== 16'h0 || act !== expv) begin
      miscompares++;
      $display("FAIL midcount_async_reset: out4=%h out1=%h chg4=%b", out4, out1, chg4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv || out4[7] !== (e >= 6) || out1[7] !== (e >= 3)) begin
        miscompares++;
        $display("FAIL midcount_restart e=%0d: out4=%h out1=%h got %h want %h",
                 e, out4, out1, act, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) < 3) sw_in[$urandom_range(0, 15)] ^= 1'b1;
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL random c=%0d: got %h want %h", c, act, expv);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
